alu_serial_responder: RTL and testbench



---
 rtl/alu_pkg.sv | 61 ++++++
 rtl/alu_tx_shifter.sv | 62 ++++++
 rtl/alu_serial_responder.sv | 182 ++++++++++++++++++
 tb/tb_alu_serial_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, opcode/state encodings and word-format helpers for the
// ALU serial link responder.
package alu_pkg;

  localparam int WORD_LEN    = 10;
  localparam int FRAME_WORDS = 3;
  localparam int RESP_BITS   = WORD_LEN * FRAME_WORDS;

  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CMD  = 1'b1;

  localparam logic [3:0] WORD_LAST = 4'(WORD_LEN - 1);
  localparam logic [4:0] RESP_LAST = 5'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_INV2 = 3'b010,
    OP_INV3 = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_MUL  = 3'b110,
    OP_NONE = 3'b111
  } operation_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_GET_CMD,
    ST_EXEC,
    ST_TX
  } state_t;

  function automatic logic parity9(input logic [8:0] bits);
    return ^bits;
  endfunction

  // Payload travels MSB first in word bits 1..8.
  function automatic logic [7:0] word_payload(input logic [WORD_LEN-1:0] w);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[7-i] = w[1+i];
    return p;
  endfunction

  function automatic logic [WORD_LEN-1:0] make_word(input logic t, input logic [7:0] p);
    logic [WORD_LEN-1:0] w;
    w[0] = t;
    for (int i = 0; i < 8; i++) w[1+i] = p[7-i];
    w[9] = parity9(w[8:0]);
    return w;
  endfunction

  function automatic logic op_valid(input operation_t op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_tx_shifter.sv
// Loads a 30-bit response and shifts it out LSB first, framing it with
// dout_valid for exactly RESP_BITS cycles.
module alu_tx_shifter
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [RESP_BITS-1:0] data_i,
  output logic                 dout_o,
  output logic                 dout_valid_o,
  output logic                 last_o
);

  logic [RESP_BITS-1:0] shift_q, shift_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 dout_q, dout_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    dout_d  = dout_q;
    if (load_i) begin
      // Bit 0 goes straight to the output; the remainder waits in shift_q.
      dout_d  = data_i[0];
      shift_d = data_i >> 1;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q) begin
      if (cnt_q == RESP_LAST) begin
        valid_d = 1'b0;
        dout_d  = 1'b0;
        cnt_d   = '0;
      end else begin
        dout_d  = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + 5'd1;
      end
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign last_o       = valid_q && (cnt_q == RESP_LAST);

endmodule

// File: rtl/alu_serial_responder.sv
// DUT end of the ALU serial link: deserialises an A/B/command frame, runs the
// ALU and returns a 3-word response through alu_tx_shifter.
module alu_serial_responder
  import alu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable_n,
  input  logic din,
  output logic dout,
  output logic dout_valid
);

  state_t               state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [WORD_LEN-1:0]  word_q, word_d;
  logic [7:0]           a_q, a_d, b_q, b_d;
  operation_t           op_q, op_d;
  logic                 err_par_q, err_par_d;
  logic                 err_seq_q, err_seq_d;
  logic                 err_op_q, err_op_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic                 load_q, load_d;

  logic [WORD_LEN-1:0]  word_full;
  logic [7:0]           payload;
  logic                 tx_last;

  logic [8:0]  sum9, diff9;
  logic [15:0] prod16, alu_r;
  logic        alu_c, alu_v, alu_z, alu_n, any_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      word_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_NONE;
      err_par_q <= 1'b0;
      err_seq_q <= 1'b0;
      err_op_q  <= 1'b0;
      resp_q    <= '0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      err_par_q <= err_par_d;
      err_seq_q <= err_seq_d;
      err_op_q  <= err_op_d;
      resp_q    <= resp_d;
      load_q    <= load_d;
    end
  end

  always_comb begin
    sum9    = {1'b0, a_q} + {1'b0, b_q};
    diff9   = {1'b0, a_q} - {1'b0, b_q};
    prod16  = 16'(a_q) * 16'(b_q);
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    any_err = err_par_q || err_seq_q || err_op_q;
    case (op_q)
      OP_AND: alu_r = {8'h00, a_q & b_q};
      OP_OR:  alu_r = {8'h00, a_q | b_q};
      OP_ADD: begin
        alu_r = {7'h00, sum9};
        alu_c = sum9[8];
        alu_v = (a_q[7] == b_q[7]) && (sum9[7] != a_q[7]);
      end
      OP_SUB: begin
        alu_r = {7'h00, diff9};
        alu_c = diff9[8];
        alu_v = (a_q[7] != b_q[7]) && (diff9[7] != a_q[7]);
      end
      OP_MUL: alu_r = prod16;
      default: alu_r = '0;
    endcase
    alu_z = (alu_r == 16'h0000);
    alu_n = (op_q == OP_MUL) ? alu_r[15] : alu_r[7];
    if (any_err) begin
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      alu_z = 1'b0;
      alu_n = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    err_par_d = err_par_q;
    err_seq_d = err_seq_q;
    err_op_d  = err_op_q;
    resp_d    = resp_q;
    load_d    = 1'b0;
    word_full = word_q;
    word_full[bit_cnt_q] = din;
    payload   = word_payload(word_full);

    case (state_q)
      ST_IDLE, ST_GET_A, ST_GET_B, ST_GET_CMD: begin
        if (enable_n) begin
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
          // First bit of word A also opens a fresh error record for the frame.
          word_d    = word_full;
          err_par_d = 1'b0;
          err_seq_d = 1'b0;
          err_op_d  = 1'b0;
          bit_cnt_d = 4'd1;
          state_d   = ST_GET_A;
        end else if (bit_cnt_q == WORD_LAST) begin
          word_d    = word_full;
          bit_cnt_d = '0;
          if (parity9(word_full[8:0]) != word_full[9]) err_par_d = 1'b1;
          case (state_q)
            ST_GET_A: begin
              a_d = payload;
              if (word_full[0] != TYPE_DATA) err_seq_d = 1'b1;
              state_d = ST_GET_B;
            end
            ST_GET_B: begin
              b_d = payload;
              if (word_full[0] != TYPE_DATA) err_seq_d = 1'b1;
              state_d = ST_GET_CMD;
            end
            default: begin
              op_d = operation_t'(payload[2:0]);
              if (word_full[0] != TYPE_CMD) err_seq_d = 1'b1;
              if (!op_valid(operation_t'(payload[2:0]))) err_op_d = 1'b1;
              state_d = ST_EXEC;
            end
          endcase
        end else begin
          word_d    = word_full;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      ST_EXEC: begin
        bit_cnt_d = '0;
        resp_d = {make_word(TYPE_DATA, alu_r[7:0]),
                  make_word(TYPE_DATA, alu_r[15:8]),
                  make_word(TYPE_CMD, {err_par_q, err_seq_q, err_op_q,
                                       alu_c, alu_v, alu_z, alu_n, 1'b0})};
        load_d  = 1'b1;
        state_d = ST_TX;
      end
      ST_TX: begin
        bit_cnt_d = '0;
        if (tx_last) state_d = ST_IDLE;
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  alu_tx_shifter u_tx (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load_q),
    .data_i       (resp_q),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .last_o       (tx_last)
  );

endmodule

// File: tb/tb_alu_serial_responder.sv
// Directed and randomized frames against a behavioural ALU/response model.
module tb_alu_serial_responder;

  logic clk;
  logic reset;
  logic enable_n;
  logic din;
  logic dout;
  logic dout_valid;

  int checks = 0;
  int errors = 0;

  alu_serial_responder dut (
    .clk        (clk),
    .reset      (reset),
    .enable_n   (enable_n),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] mk_word(input logic t, input logic [7:0] p);
    logic [9:0] w;
    w[0] = t;
    for (int i = 0; i < 8; i++) w[1+i] = p[7-i];
    w[9] = ^w[8:0];
    return w;
  endfunction

  function automatic logic [7:0] pay(input logic [9:0] w);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[7-i] = w[1+i];
    return p;
  endfunction

  // Expected 30-bit response computed from the words as sent.
  function automatic logic [29:0] model_resp(input logic [9:0] wa, input logic [9:0] wb,
                                             input logic [9:0] wc);
    int a, b, op, r, sa, sb, s;
    bit pe, se, oe, c, v, z, n;
    logic [7:0]  pc, fl;
    logic [15:0] rv;
    a  = int'(pay(wa));
    b  = int'(pay(wb));
    pc = pay(wc);
    op = int'(pc[2:0]);
    pe = (^wa) || (^wb) || (^wc);
    se = (wa[0] != 1'b0) || (wb[0] != 1'b0) || (wc[0] != 1'b1);
    oe = !(op inside {0, 1, 4, 5, 6});
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r = 0; c = 0; v = 0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      4: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      5: begin r = (a - b) & 511; c = (a < b); s = sa - sb; v = (s > 127) || (s < -128); end
      6: r = a * b;
      default: r = 0;
    endcase
    z = (r == 0);
    n = (op == 6) ? (r >= 32768) : (((r >> 7) & 1) == 1);
    if (pe || se || oe) begin
      r = 0; c = 0; v = 0; z = 0; n = 0;
    end
    rv = r[15:0];
    fl = {pe, se, oe, c, v, z, n, 1'b0};
    return {mk_word(1'b0, rv[7:0]), mk_word(1'b0, rv[15:8]), mk_word(1'b1, fl)};
  endfunction

  task automatic drive_bits(input logic [29:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      enable_n = 1'b0;
      din      = bits[i];
    end
    @(negedge clk);
    enable_n = 1'b1;
    din      = 1'($urandom);
  endtask

  // Called on the negedge after the last command bit was sampled.
  task automatic collect(input string tag, output logic [29:0] resp);
    int lat;
    int vcnt;
    lat  = 0;
    resp = 'x;
    do begin
      @(negedge clk);
      lat++;
    end while (!dout_valid && lat < 8);
    check({tag, "_latency"}, lat, 2);
    if (!dout_valid) return;
    resp[0] = dout;
    vcnt    = 1;
    for (int i = 1; i < 30; i++) begin
      @(negedge clk);
      enable_n = 1'($urandom);
      din      = 1'($urandom);
      resp[i]  = dout;
      if (dout_valid) vcnt++;
    end
    @(negedge clk);
    enable_n = 1'b1;
    check({tag, "_valid_len"}, vcnt, 30);
    check({tag, "_valid_fall"}, dout_valid, 0);
  endtask

  task automatic run_frame(input string tag, input logic [9:0] wa, input logic [9:0] wb,
                           input logic [9:0] wc, output logic [29:0] resp);
    drive_bits({wc, wb, wa}, 30);
    collect(tag, resp);
    check({tag, "_resp"}, resp, model_resp(wa, wb, wc));
  endtask

  logic [29:0] resp;
  logic [9:0]  wa, wb, wc;
  int          spur;

  initial begin
    reset    = 1'b0;
    enable_n = 1'b1;
    din      = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    spur  = 0;
    repeat (20) begin
      @(negedge clk);
      if (dout_valid) spur++;
    end
    check("idle_no_resp", spur, 0);

    // ADD F0+20
    run_frame("add", mk_word(1'b0, 8'hF0), mk_word(1'b0, 8'h20), mk_word(1'b1, 8'h04), resp);
    check("add_flags", pay(resp[9:0]), 8'h10);
    check("add_r", {pay(resp[19:10]), pay(resp[29:20])}, 16'h0110);
    check("add_types", {resp[20], resp[10], resp[0]}, 3'b001);
    check("add_parity", {^resp[29:20], ^resp[19:10], ^resp[9:0]}, 3'b000);

    // MUL FF*FF
    run_frame("mul", mk_word(1'b0, 8'hFF), mk_word(1'b0, 8'hFF), mk_word(1'b1, 8'h06), resp);
    check("mul_flags", pay(resp[9:0]), 8'h02);
    check("mul_r", {pay(resp[19:10]), pay(resp[29:20])}, 16'hFE01);

    // SUB 00-01
    run_frame("sub", mk_word(1'b0, 8'h00), mk_word(1'b0, 8'h01), mk_word(1'b1, 8'h05), resp);
    check("sub_flags", pay(resp[9:0]), 8'h12);
    check("sub_r", {pay(resp[19:10]), pay(resp[29:20])}, 16'h01FF);

    // Parity error in word B
    wb = mk_word(1'b0, 8'h20);
    wb[9] = ~wb[9];
    run_frame("par", mk_word(1'b0, 8'hF0), wb, mk_word(1'b1, 8'h04), resp);
    check("par_flags", pay(resp[9:0]), 8'h80);
    check("par_r", {pay(resp[19:10]), pay(resp[29:20])}, 16'h0000);

    // Command word in slot A
    run_frame("seq", mk_word(1'b1, 8'h12), mk_word(1'b0, 8'h34), mk_word(1'b1, 8'h04), resp);
    check("seq_flags", pay(resp[9:0]), 8'h40);

    // Invalid opcode
    run_frame("op", mk_word(1'b0, 8'h12), mk_word(1'b0, 8'h34), mk_word(1'b1, 8'h03), resp);
    check("op_flags", pay(resp[9:0]), 8'h20);

    // Abort after 15 bits, then a clean AND frame
    drive_bits(30'($urandom), 15);
    spur = 0;
    repeat (40) begin
      @(negedge clk);
      if (dout_valid) spur++;
    end
    check("abort_no_resp", spur, 0);
    run_frame("and", mk_word(1'b0, 8'h0F), mk_word(1'b0, 8'h3C), mk_word(1'b1, 8'h00), resp);
    check("and_r", {pay(resp[19:10]), pay(resp[29:20])}, 16'h000C);
    check("and_flags", pay(resp[9:0]), 8'h00);

    // Randomized frames, with occasional parity and slot-type corruption
    for (int f = 0; f < 24; f++) begin
      int sel;
      wa = mk_word(1'b0, 8'($urandom));
      wb = mk_word(1'b0, 8'($urandom));
      wc = mk_word(1'b1, {5'($urandom), 3'($urandom_range(0, 7))});
      sel = $urandom_range(0, 9);
      if (sel == 0) wa[9] = ~wa[9];
      if (sel == 1) wc[9] = ~wc[9];
      if (sel == 2) wb = mk_word(1'b1, pay(wb));
      if (sel == 3) wc = mk_word(1'b0, pay(wc));
      run_frame("rand", wa, wb, wc, resp);
    end

    // Reset in the middle of a response
    drive_bits({mk_word(1'b1, 8'h06), mk_word(1'b0, 8'h55), mk_word(1'b0, 8'hAA)}, 30);
    spur = 0;
    while (!dout_valid && spur < 8) begin
      @(negedge clk);
      spur++;
    end
    check("mid_tx_started", dout_valid, 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_tx_rst_valid", dout_valid, 0);
    check("mid_tx_rst_dout", dout, 0);
    @(negedge clk);
    reset = 1'b0;
    spur  = 0;
    repeat (40) begin
      @(negedge clk);
      if (dout_valid) spur++;
    end
    check("mid_tx_no_resume", spur, 0);

    run_frame("post_rst", mk_word(1'b0, 8'h7F), mk_word(1'b0, 8'h01), mk_word(1'b1, 8'h04), resp);
    check("post_rst_flags", pay(resp[9:0]), 8'h0A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
